// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing definitions for the raster generator: named timing sets for
//   the common modes, a line/frame total helper and a parameter legality check
//   evaluated at elaboration time by vga_timing_gen.
package vga_timing_pkg;

  // One complete mode description; pclk_khz documents the pixel clock the
  // mode expects from the top-level clock wizard.
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    int unsigned pclk_khz;
  } timing_t;

  localparam timing_t XGA_1024x768_60 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    pclk_khz: 65000
  };

  localparam timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    pclk_khz: 25175
  };

  // Total count of one line (or one frame in lines): sync + bp + active + fp.
  function automatic int unsigned span_total(input int unsigned sync_w,
                                             input int unsigned bp,
                                             input int unsigned active,
                                             input int unsigned fp);
    return sync_w + bp + active + fp;
  endfunction

  // True when every field is non-zero, both totals fit in cw bits and the
  // output pipeline has at least one stage.
  function automatic bit timing_legal(input int unsigned h_active,
                                      input int unsigned h_fp,
                                      input int unsigned h_sync,
                                      input int unsigned h_bp,
                                      input int unsigned v_active,
                                      input int unsigned v_fp,
                                      input int unsigned v_sync,
                                      input int unsigned v_bp,
                                      input int unsigned cw,
                                      input int unsigned pipe_dly);
    longint unsigned lim;
    bit ok;
    lim = longint'(64'd1) << cw;
    ok = (h_active != 0) && (h_fp != 0) && (h_sync != 0) && (h_bp != 0) &&
         (v_active != 0) && (v_fp != 0) && (v_sync != 0) && (v_bp != 0) &&
         (pipe_dly >= 1) && (cw >= 1) && (cw < 32);
    if (longint'(span_total(h_sync, h_bp, h_active, h_fp)) >= lim) ok = 1'b0;
    if (longint'(span_total(v_sync, v_bp, v_active, v_fp)) >= lim) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Control and raster-output bundle of vga_timing_gen.
//   master : the generator (samples pix_ce/run, drives sync/enable/position)
//   slave  : a downstream pixel pipeline consuming the raster
//   Signals: pix_ce, run (control in); vga_hs, vga_vs, en, hc, vc, sol, sof,
//   frame_cnt (raster out).
interface vga_timing_gen_if #(
  parameter int CW  = 12,
  parameter int FCW = 8
);
  logic           pix_ce;
  logic           run;
  logic           vga_hs;
  logic           vga_vs;
  logic           en;
  logic [CW-1:0]  hc;
  logic [CW-1:0]  vc;
  logic           sol;
  logic           sof;
  logic [FCW-1:0] frame_cnt;

  modport master (
    input  pix_ce, run,
    output vga_hs, vga_vs, en, hc, vc, sol, sof, frame_cnt
  );

  modport slave (
    output pix_ce, run,
    input  vga_hs, vga_vs, en, hc, vc, sol, sof, frame_cnt
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   WIDTH x DEPTH shift register advanced by a clock-enable.
//   clk     : clock
//   rst     : synchronous reset, active-low; loads rst_val into every stage
//   ce      : shift enable
//   rst_val : value every stage takes in reset
//   d / q   : input / output after DEPTH enabled cycles
module vga_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Newest sample lives in the low slice, oldest in the high slice.
  logic [DEPTH*WIDTH-1:0] chain_q;
  logic [DEPTH*WIDTH-1:0] chain_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign chain_d = d;
    end else begin : g_multi
      assign chain_d = {chain_q[(DEPTH-1)*WIDTH-1:0], d};
    end
  endgenerate

  // NOTE: every stage is reset, not just the last one: any stage left holding
  // stale data would surface on q a few enabled cycles after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_q <= {DEPTH{rst_val}};
    end else if (ce) begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator running on an external pixel clock
//   with clock-enable. Line order from count 0: sync, back porch, active,
//   front porch. Decoded sync/enable/position go through a PIPE_DLY-stage
//   delay line so outputs align with downstream fetch latency.
//   vga_clk : pixel clock
//   rst     : synchronous reset, active-low
//   bus     : vga_timing_gen_if master (pix_ce, run in; raster out)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int PIPE_DLY = 1,
  parameter int FCW      = 8
) (
  input  logic vga_clk,
  input  logic rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = int'(span_total(H_SYNC, H_BP, H_ACTIVE, H_FP));
  localparam int V_TOTAL = int'(span_total(V_SYNC, V_BP, V_ACTIVE, V_FP));
  localparam bit CFG_OK  = timing_legal(H_ACTIVE, H_FP, H_SYNC, H_BP,
                                        V_ACTIVE, V_FP, V_SYNC, V_BP,
                                        CW, PIPE_DLY);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_ACT_BEG   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACTIVE);

  // Bundled stage layout: {hs, vs, en, sol, sof, hc, vc}.
  localparam int DW = 5 + 2 * CW;
  localparam logic [DW-1:0] INACTIVE = {~HS_POL, ~VS_POL, 3'b000, {(2*CW){1'b0}}};

  logic [CW-1:0]  hcnt;
  logic [CW-1:0]  vcnt;
  logic [FCW-1:0] frame_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge vga_clk) begin
    if (!rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_cnt_q <= '0;
    end else if (bus.pix_ce) begin
      if (!bus.run) begin
        hcnt        <= '0;
        vcnt        <= '0;
        frame_cnt_q <= '0;
      end else if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt        <= '0;
          frame_cnt_q <= frame_cnt_q + FCW'(1);
        end else begin
          vcnt <= vcnt + CW'(1);
        end
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  logic          hs_a, vs_a, h_act, v_act, act, sol_a, sof_a;
  logic [CW-1:0] hc_a, vc_a;
  logic [DW-1:0] stage_d;
  logic [DW-1:0] stage_q;

  assign hs_a  = hcnt < H_SYNC_END;
  assign vs_a  = vcnt < V_SYNC_END;
  assign h_act = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END);
  assign v_act = (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
  assign act   = h_act && v_act;
  assign sol_a = act && (hcnt == H_ACT_BEG);
  assign sof_a = sol_a && (vcnt == V_ACT_BEG);
  assign hc_a  = act ? hcnt - H_ACT_BEG : '0;
  assign vc_a  = act ? vcnt - V_ACT_BEG : '0;

  // While stopped the counters sit at 0, which decodes as sync-asserted;
  // feed the inactive vector instead so the pipeline flushes to idle.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch on any path that skips the if.
  always_comb begin
    stage_d = INACTIVE;
    if (bus.run) begin
      stage_d = {hs_a ? HS_POL : ~HS_POL, vs_a ? VS_POL : ~VS_POL,
                 act, sol_a, sof_a, hc_a, vc_a};
    end
  end

  vga_delay_line #(
    .WIDTH (DW),
    .DEPTH (PIPE_DLY)
  ) u_out_dly (
    .clk     (vga_clk),
    .rst     (rst),
    .ce      (bus.pix_ce),
    .rst_val (INACTIVE),
    .d       (stage_d),
    .q       (stage_q)
  );

  assign {bus.vga_hs, bus.vga_vs, bus.en, bus.sol, bus.sof, bus.hc, bus.vc} = stage_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Drives three small-raster instances (PIPE_DLY=1 active-low sync,
//   PIPE_DLY=3 active-low sync, PIPE_DLY=1 active-high sync) from one shared
//   stimulus and compares every output against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HS + HB + HA + HF;  // 16
  localparam int VT = VS + VB + VA + VF;  // 8
  localparam int CW = 12, FCW = 8;

  typedef struct packed {
    logic          hs_a;
    logic          vs_a;
    logic          act;
    logic          sol;
    logic          sof;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
  } dec_t;

  logic clk = 1'b0;
  logic rst, pix_ce, run;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW), .FCW(FCW)) bus1 ();
  vga_timing_gen_if #(.CW(CW), .FCW(FCW)) bus3 ();
  vga_timing_gen_if #(.CW(CW), .FCW(FCW)) busp ();

  assign bus1.pix_ce = pix_ce;  assign bus1.run = run;
  assign bus3.pix_ce = pix_ce;  assign bus3.run = run;
  assign busp.pix_ce = pix_ce;  assign busp.run = run;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .PIPE_DLY(1), .FCW(FCW))
    dut1 (.vga_clk(clk), .rst(rst), .bus(bus1.master));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .PIPE_DLY(3), .FCW(FCW))
    dut3 (.vga_clk(clk), .rst(rst), .bus(bus3.master));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .PIPE_DLY(1), .FCW(FCW))
    dutp (.vga_clk(clk), .rst(rst), .bus(busp.master));

  // Reference model: p counts enabled running pixels since reset/stop; the
  // raster position and frame count follow from plain division.
  int   p = 0;
  dec_t hist [3];

  function automatic dec_t decode(input int pix);
    dec_t d;
    int h, v;
    h = pix % HT;
    v = (pix / HT) % VT;
    d.hs_a = (h < HS);
    d.vs_a = (v < VS);
    d.act  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    d.sol  = d.act && (h == HS + HB);
    d.sof  = d.sol && (v == VS + VB);
    d.hc   = d.act ? CW'(h - (HS + HB)) : '0;
    d.vc   = d.act ? CW'(v - (VS + VB)) : '0;
    return d;
  endfunction

  function automatic logic [63:0] exp_vec(input dec_t e, input bit hp, input bit vp);
    return 64'({e.hs_a ? hp : ~hp, e.vs_a ? vp : ~vp, e.act, e.sol, e.sof, e.hc, e.vc});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic u);
    if (!r) begin
      p = 0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else if (c) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = u ? decode(p) : dec_t'('0);
      p = u ? p + 1 : 0;
    end
  endtask

  task automatic compare_all();
    logic [63:0] fexp;
    fexp = 64'((p / (HT * VT)) % (1 << FCW));
    check("dly1_out", 64'({bus1.vga_hs, bus1.vga_vs, bus1.en, bus1.sol, bus1.sof, bus1.hc, bus1.vc}),
          exp_vec(hist[0], 1'b0, 1'b0));
    check("dly3_out", 64'({bus3.vga_hs, bus3.vga_vs, bus3.en, bus3.sol, bus3.sof, bus3.hc, bus3.vc}),
          exp_vec(hist[2], 1'b0, 1'b0));
    check("pol1_out", 64'({busp.vga_hs, busp.vga_vs, busp.en, busp.sol, busp.sof, busp.hc, busp.vc}),
          exp_vec(hist[0], 1'b1, 1'b1));
    check("dly1_frame", 64'(bus1.frame_cnt), fexp);
    check("dly3_frame", 64'(bus3.frame_cnt), fexp);
    check("pol1_frame", 64'(busp.frame_cnt), fexp);
  endtask

  // Inputs change just after an edge, the model follows the edge, outputs
  // are compared 1 time unit later.
  task automatic step(input logic r, input logic c, input logic u);
    rst = r; pix_ce = c; run = u;
    @(posedge clk);
    model_update(r, c, u);
    #1;
    compare_all();
  endtask

  initial begin
    int en_cnt, sol_cnt, sof_cnt, first_en, found;
    logic run_r;
    rst = 1'b0; pix_ce = 1'b1; run = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    #1;

    // Reset state
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("rst_hs_idle", 64'(bus1.vga_hs), 64'd1);
    check("rst_en_idle", 64'(bus1.en), 64'd0);
    check("rst_pol_hs_idle", 64'(busp.vga_hs), 64'd0);

    // One full frame with PIX_CE=1
    en_cnt = 0; sol_cnt = 0; first_en = -1;
    for (int i = 1; i <= HT * VT; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (bus1.en) en_cnt++;
      if (bus1.sol) sol_cnt++;
      if (bus1.en && first_en < 0) first_en = i;
    end
    check("frame_en_cycles", 64'(en_cnt), 64'(HA * VA));
    check("frame_sol_pulses", 64'(sol_cnt), 64'(VA));
    check("first_en_cycle", 64'(first_en), 64'((VS + VB) * HT + HS + HB + 1));
    check("frame_cnt_after_1", 64'(bus1.frame_cnt), 64'd1);

    // PIX_CE toggling: one frame takes twice as many clocks
    en_cnt = 0; sof_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1, logic'(i % 2 == 0), 1'b1);
      if (bus1.en) en_cnt++;
      if (bus1.sof) sof_cnt++;
    end
    check("ce_en_clk_cycles", 64'(en_cnt), 64'(2 * HA * VA));
    check("ce_sof_clk_cycles", 64'(sof_cnt), 64'd2);

    // Reset mid-active at VC=2, HC=5
    found = 0;
    for (int i = 0; i < 2 * HT * VT && found == 0; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (bus1.en && bus1.vc == 2 && bus1.hc == 5) found = 1;
    end
    check("mid_active_reached", 64'(found), 64'd1);
    step(1'b0, 1'b1, 1'b1);
    check("midrst_out", 64'({bus1.vga_hs, bus1.vga_vs, bus1.en, bus1.hc, bus1.vc}),
          64'({1'b1, 1'b1, 1'b0, {CW{1'b0}}, {CW{1'b0}}}));
    check("midrst_frame", 64'(bus1.frame_cnt), 64'd0);
    step(1'b1, 1'b1, 1'b1);
    check("restart_vsync", 64'({bus1.vga_hs, bus1.vga_vs}), 64'd0);

    // RUN=0 for 20 cycles mid-frame, active-high sync instance
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("stop_hs_pol1", 64'(busp.vga_hs), 64'd0);
      check("stop_en_pos", 64'({busp.en, busp.hc, busp.vc, busp.frame_cnt}), 64'd0);
    end
    for (int i = 0; i < HT; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check("resume_hs_pol1", 64'(busp.vga_hs), 64'(i < HS));
    end

    // Randomised control: PIX_CE gaps, RUN bursts, occasional reset
    run_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) run_r = ~run_r;
      step(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 3) != 0), run_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
